// File: rtl/logic_sweep_pkg.sv
// Shared types and constants for the logic unit sweep checker.
// Result slot order matches the y1..y5 ports of the logic unit.
package logic_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam int RES_AND  = 0;
  localparam int RES_OR   = 1;
  localparam int RES_XOR  = 2;
  localparam int RES_NAND = 3;
  localparam int RES_NOR  = 4;
  localparam int NUM_RES  = 5;

endpackage

// File: rtl/logic_sweep_checker_ref.sv
// Golden bitwise logic results for one operand pair.
// Purely combinational; the checker feeds it its own driven operands.
module logic_ref #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_and,
  output logic [WIDTH-1:0] y_or,
  output logic [WIDTH-1:0] y_xor,
  output logic [WIDTH-1:0] y_nand,
  output logic [WIDTH-1:0] y_nor
);

  assign y_and  = a & b;
  assign y_or   = a | b;
  assign y_xor  = a ^ b;
  assign y_nand = ~(a & b);
  assign y_nor  = ~(a | b);

endmodule

// File: rtl/logic_sweep_checker.sv
// Built-in self-test for the bitwise logic unit: sweeps every {a,b}
// pair, checks all five results and records the first failure.
module logic_sweep_checker
  import logic_sweep_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  input  logic [WIDTH-1:0]     y1_in,
  input  logic [WIDTH-1:0]     y2_in,
  input  logic [WIDTH-1:0]     y3_in,
  input  logic [WIDTH-1:0]     y4_in,
  input  logic [WIDTH-1:0]     y5_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [2*WIDTH-1:0]   fail_vec,
  output logic [NUM_RES-1:0]   fail_mask
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam state_t NXT = (SETTLE == 0) ? CHECK : WAIT;

  state_t                           state;
  logic [VW-1:0]                    vec;
  logic [CW-1:0]                    cnt;
  logic [NUM_RES-1:0][WIDTH-1:0]    expv;
  logic [NUM_RES-1:0][WIDTH-1:0]    got;
  logic [NUM_RES-1:0]               miss;
  logic                             any_miss;

  assign {a_out, b_out} = vec;

  logic_ref #(.WIDTH(WIDTH)) u_ref (
    .a      (a_out),
    .b      (b_out),
    .y_and  (expv[RES_AND]),
    .y_or   (expv[RES_OR]),
    .y_xor  (expv[RES_XOR]),
    .y_nand (expv[RES_NAND]),
    .y_nor  (expv[RES_NOR])
  );

  assign got = {y5_in, y4_in, y3_in, y2_in, y1_in};

  always_comb begin
    miss = '0;
    for (int i = 0; i < NUM_RES; i++)
      miss[i] = (got[i] != expv[i]);
  end

  assign any_miss = |miss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      fail_mask <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            vec       <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
            fail_mask <= '0;
            state     <= NXT;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          if (any_miss) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) begin
              fail_vec  <= vec;
              fail_mask <= miss;
            end
          end
          // pass must already reflect this final check during DONE
          if (&vec) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !any_miss;
            state <= DONE;
          end else begin
            vec   <= vec + 1'b1;
            state <= NXT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Self-checking bench: fault-injectable logic unit model feeding two
// checker instances (SETTLE=1 and SETTLE=0), compared with a sweep model.
module tb_logic_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  int   sel;
  int   errors = 0;
  int   checks = 0;

  int         fr;
  logic [3:0] fm;
  int         fmode;

  function automatic logic [4:0][3:0] unit(
    input logic [3:0] a, input logic [3:0] b,
    input int r, input logic [3:0] m, input int mode);
    logic [4:0][3:0] y;
    y[0] = a & b;
    y[1] = a | b;
    y[2] = a ^ b;
    y[3] = ~(a & b);
    y[4] = ~(a | b);
    case (mode)
      1: y[r] = y[r] & ~m;
      2: y[r] = y[r] | m;
      3: y[r] = y[r] ^ m;
      default: ;
    endcase
    return y;
  endfunction

  logic start0, start1;
  assign start0 = start && (sel == 0);
  assign start1 = start && (sel == 1);

  logic [3:0] a0, b0, a1, b1;
  logic [4:0][3:0] u0, u1;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [8:0] err0, err1;
  logic [7:0] fv0, fv1;
  logic [4:0] fk0, fk1;

  always_comb u0 = unit(a0, b0, fr, fm, fmode);
  always_comb u1 = unit(a1, b1, fr, fm, fmode);

  logic_sweep_checker #(.WIDTH(4), .SETTLE(1)) dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .a_out(a0), .b_out(b0),
    .y1_in(u0[0]), .y2_in(u0[1]), .y3_in(u0[2]),
    .y4_in(u0[3]), .y5_in(u0[4]),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fv0), .fail_mask(fk0)
  );

  logic_sweep_checker #(.WIDTH(4), .SETTLE(0)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .a_out(a1), .b_out(b1),
    .y1_in(u1[0]), .y2_in(u1[1]), .y3_in(u1[2]),
    .y4_in(u1[3]), .y5_in(u1[4]),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1), .fail_mask(fk1)
  );

  logic       busy_s, done_s, pass_s;
  logic [8:0] err_s;
  logic [7:0] fv_s, vec_s;
  logic [4:0] fk_s;
  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;
  assign pass_s = sel ? pass1 : pass0;
  assign err_s  = sel ? err1 : err0;
  assign fv_s   = sel ? fv1 : fv0;
  assign fk_s   = sel ? fk1 : fk0;
  assign vec_s  = sel ? {a1, b1} : {a0, b0};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Walk every operand pair through the faulty unit and score it.
  task automatic model(output int cnt, output logic [7:0] fv,
                       output logic [4:0] fk);
    logic [4:0][3:0] good, bad;
    logic [4:0] m;
    cnt = 0; fv = '0; fk = '0;
    for (int v = 0; v < 256; v++) begin
      good = unit(4'(v / 16), 4'(v % 16), 0, 4'h0, 0);
      bad  = unit(4'(v / 16), 4'(v % 16), fr, fm, fmode);
      m = '0;
      for (int i = 0; i < 5; i++) m[i] = (good[i] != bad[i]);
      if (m != 0) begin
        if (cnt == 0) begin fv = 8'(v); fk = m; end
        cnt++;
      end
    end
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_busy"}, 32'(busy_s), 0);
    chk({tag, "_done"}, 32'(done_s), 0);
    chk({tag, "_pass"}, 32'(pass_s), 0);
    chk({tag, "_err"}, 32'(err_s), 0);
    chk({tag, "_fvec"}, 32'(fv_s), 0);
    chk({tag, "_fmask"}, 32'(fk_s), 0);
    chk({tag, "_ab"}, 32'(vec_s), 0);
  endtask

  task automatic sweep(input string tag, input int settle,
                       input int pulse_at);
    int c, lat, bad, per, ecnt;
    logic [7:0] efv;
    logic [4:0] efk;
    per = settle + 1;
    model(ecnt, efv, efk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c = 0; lat = -1; bad = 0;
    while (c < 3000) begin
      if (done_s === 1'b1) begin lat = c; break; end
      if (int'(vec_s) != c / per || busy_s !== 1'b1) bad++;
      start = (c == pulse_at);
      @(posedge clk);
      #1;
      c++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(256 * per));
    chk({tag, "_steps"}, 32'(bad), 0);
    chk({tag, "_busy_done"}, 32'(busy_s), 0);
    chk({tag, "_pass"}, 32'(pass_s), 32'(ecnt == 0));
    chk({tag, "_err"}, 32'(err_s), 32'(ecnt));
    chk({tag, "_fvec"}, 32'(fv_s), 32'(efv));
    chk({tag, "_fmask"}, 32'(fk_s), 32'(efk));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done_s), 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_idle"}, 32'(busy_s), 0);
    chk({tag, "_pass_hold"}, 32'(pass_s), 32'(ecnt == 0));
  endtask

  task automatic set_fault(input int r, input logic [3:0] m, input int mode);
    fr = r; fm = m; fmode = mode;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sel = 0;
    set_fault(0, 4'h0, 0);
    #12;
    sel = 0; zero_outs("rst0");
    sel = 1; zero_outs("rst1");
    @(negedge clk);
    reset = 1'b0;

    sel = 0;
    sweep("clean", 1, -1);
    set_fault(2, 4'hF, 1);
    sweep("y3_zero", 1, -1);
    set_fault(0, 4'h1, 2);
    sweep("y1_b0_one", 1, -1);
    set_fault(0, 4'h0, 0);
    sweep("restart_ignored", 1, 50);

    for (int k = 0; k < 3; k++) begin
      set_fault($urandom_range(0, 4), 4'($urandom_range(1, 15)),
                $urandom_range(1, 3));
      sweep($sformatf("rand%0d", k), 1, -1);
    end

    set_fault(2, 4'hF, 1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    zero_outs("midreset");
    @(negedge clk);
    reset = 1'b0;
    set_fault(0, 4'h0, 0);
    sweep("after_reset", 1, -1);

    sel = 1;
    sweep("s0_clean", 0, -1);
    set_fault(4, 4'hF, 3);
    sweep("s0_y5_inv", 0, -1);
    set_fault($urandom_range(0, 4), 4'($urandom_range(1, 15)),
              $urandom_range(1, 3));
    sweep("s0_rand", 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
